// File: rtl/al4s3b_count_monitor.sv
// Count-step monitor with error log and periodic snapshot FIFO,
// exposed on the Wishbone slave bus of the counter block.
module al4s3b_count_monitor #(
  parameter int          ADDRWIDTH     = 7,
  parameter int          DATAWIDTH     = 32,
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [15:0] DEF_PERIOD    = 16'h0100,
  parameter logic [31:0] DEF_REG_VALUE = 32'hFAB_DEF_AC
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_n_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  output logic                 WBs_ACK_o,
  input  logic [31:0]          count_i,
  output logic                 mon_err_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [ADDRWIDTH-1:0] A_CTRL   = ADDRWIDTH'(0);
  localparam logic [ADDRWIDTH-1:0] A_PERIOD = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] A_STATUS = ADDRWIDTH'(2);
  localparam logic [ADDRWIDTH-1:0] A_ERRCNT = ADDRWIDTH'(3);
  localparam logic [ADDRWIDTH-1:0] A_EPREV  = ADDRWIDTH'(4);
  localparam logic [ADDRWIDTH-1:0] A_ECUR   = ADDRWIDTH'(5);
  localparam logic [ADDRWIDTH-1:0] A_FIFO   = ADDRWIDTH'(6);

  logic          mon_en, snap_en;
  logic [15:0]   period, pcnt;
  logic [31:0]   prev, err_prev, err_cur;
  logic          prev_valid, sticky, ovf;
  logic [15:0]   err_cnt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic [31:0]   rd_data;

  logic bus_sel, wr_en, ctrl_wr, per_wr, clr;
  logic empty, full, pop, push, push_ok;
  logic snap_act, tick, legal, err;
  logic unused;

  assign unused = ^{WBs_BYTE_STB_i[3:2], WBs_DAT_i[DATAWIDTH-1:16]};

  assign bus_sel = WBs_CYC_i & WBs_STB_i;
  assign wr_en   = bus_sel & WBs_WE_i & ~WBs_ACK_o;
  assign ctrl_wr = wr_en & (WBs_ADR_i == A_CTRL);
  assign per_wr  = wr_en & (WBs_ADR_i == A_PERIOD);
  assign clr     = ctrl_wr & WBs_BYTE_STB_i[1] & WBs_DAT_i[8];

  assign empty = (level == '0);
  assign full  = (level == LW'(FIFO_DEPTH));
  assign pop   = bus_sel & ~WBs_WE_i & WBs_ACK_o
               & (WBs_ADR_i == A_FIFO) & ~empty;

  assign snap_act = snap_en & (period != 16'd0);
  assign tick     = snap_act & ~per_wr
                  & (pcnt == period - 16'd1);
  assign push     = tick & ~clr & WBs_RST_n_i;
  assign push_ok  = push & (~full | pop);

  assign legal = (count_i == prev)
               | (count_i == prev + 32'd1)
               | (count_i == 32'h0)
               | (count_i == 32'hFFFF_FFFF);
  assign err   = mon_en & prev_valid & ~legal;

  assign mon_err_o = sticky;

  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_n_i) begin
      WBs_ACK_o <= 1'b0;
      mon_en    <= 1'b0;
      snap_en   <= 1'b0;
      period    <= DEF_PERIOD;
    end else begin
      WBs_ACK_o <= bus_sel & ~WBs_ACK_o;
      if (ctrl_wr & WBs_BYTE_STB_i[0])
        {snap_en, mon_en} <= WBs_DAT_i[1:0];
      if (per_wr & WBs_BYTE_STB_i[0])
        period[7:0] <= WBs_DAT_i[7:0];
      if (per_wr & WBs_BYTE_STB_i[1])
        period[15:8] <= WBs_DAT_i[15:8];
    end
  end

  // error log: first illegal step is frozen until clr
  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_n_i || clr) begin
      prev_valid <= 1'b0;
      sticky     <= 1'b0;
      err_cnt    <= '0;
      err_prev   <= '0;
      err_cur    <= '0;
    end else begin
      prev_valid <= mon_en;
      if (err) begin
        if (err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
        sticky <= 1'b1;
        if (!sticky) begin
          err_prev <= prev;
          err_cur  <= count_i;
        end
      end
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_n_i || per_wr || !snap_act)
      pcnt <= '0;
    else if (pcnt == period - 16'd1)
      pcnt <= '0;
    else
      pcnt <= pcnt + 16'd1;
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_n_i || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      if (push_ok && !pop)
        level <= level + LW'(1);
      else if (!push_ok && pop)
        level <= level - LW'(1);
      if (push && full && !pop)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    prev <= count_i;
    if (push_ok)
      mem[wptr] <= count_i;
  end

  always_comb begin
    rd_data = DEF_REG_VALUE;
    case (WBs_ADR_i)
      A_CTRL:   rd_data = {30'd0, snap_en, mon_en};
      A_PERIOD: rd_data = {16'd0, period};
      A_STATUS: rd_data = 32'({level, full, empty, ovf, sticky});
      A_ERRCNT: rd_data = {16'd0, err_cnt};
      A_EPREV:  rd_data = err_prev;
      A_ECUR:   rd_data = err_cur;
      A_FIFO:   if (!empty) rd_data = mem[rptr];
      default:  rd_data = DEF_REG_VALUE;
    endcase
  end

  assign WBs_DAT_o = DATAWIDTH'(rd_data);

endmodule

// File: tb/tb_al4s3b_count_monitor.sv
// Scoreboard bench for al4s3b_count_monitor: bus reads are
// compared against expected values queued as stimulus is applied.
module tb_al4s3b_count_monitor;

  localparam logic [31:0] DEF = 32'hFABDEFAC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  adr = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  bstb = 4'h0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ack;
  logic        mon_err;

  logic [31:0] cyc_ctr = '0;
  logic [31:0] count_man = '0;
  logic        use_ctr = 1'b0;
  wire  [31:0] count_i = use_ctr ? cyc_ctr : count_man;

  logic [31:0] last_wr_ctr = '0;
  logic [6:0]  adr_q[$];
  logic [31:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  al4s3b_count_monitor dut (
    .WBs_CLK_i      (clk),
    .WBs_RST_n_i    (rst_n),
    .WBs_ADR_i      (adr),
    .WBs_CYC_i      (cyc),
    .WBs_STB_i      (stb),
    .WBs_WE_i       (we),
    .WBs_BYTE_STB_i (bstb),
    .WBs_DAT_i      (dat_i),
    .WBs_DAT_o      (dat_o),
    .WBs_ACK_o      (ack),
    .count_i        (count_i),
    .mon_err_o      (mon_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_ctr <= cyc_ctr + 32'd1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  // All bus tasks are entered and left at posedge + 1.
  task automatic wb_rd(input logic [6:0] a,
                       output logic [31:0] d);
    int n;
    adr = a; cyc = 1'b1; stb = 1'b1;
    we = 1'b0; bstb = 4'hF;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    checks++;
    if (!ack) begin
      errors++;
      $display("FAIL rd_ack_timeout: ack=%b want 1", ack);
    end
    d = dat_o;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wb_wr(input logic [6:0] a,
                       input logic [31:0] d,
                       input logic [3:0] be);
    int n;
    adr = a; cyc = 1'b1; stb = 1'b1;
    we = 1'b1; bstb = be; dat_i = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    checks++;
    if (!ack) begin
      errors++;
      $display("FAIL wr_ack_timeout: ack=%b want 1", ack);
    end
    last_wr_ctr = cyc_ctr - 32'd1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic queue_reset_map();
    adr_q.push_back(7'd0); exp_q.push_back(32'h0);
    adr_q.push_back(7'd1); exp_q.push_back(32'h100);
    adr_q.push_back(7'd2); exp_q.push_back(32'h4);
    adr_q.push_back(7'd3); exp_q.push_back(32'h0);
    adr_q.push_back(7'd4); exp_q.push_back(32'h0);
    adr_q.push_back(7'd5); exp_q.push_back(32'h0);
    adr_q.push_back(7'd6); exp_q.push_back(DEF);
    adr_q.push_back(7'd7); exp_q.push_back(DEF);
  endtask

  task automatic test_reset();
    logic [6:0]  a;
    logic [31:0] d, e;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
    checks++;
    if (mon_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mon_err: got %b want 0", mon_err);
    end
    adr = 7'd1; cyc = 1'b1; stb = 1'b1; we = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_early: got %b want 0", ack);
    end
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_one_wait: got %b want 1", ack);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    step(1);
    queue_reset_map();
    while (adr_q.size() > 0) begin
      a = adr_q.pop_front();
      e = exp_q.pop_front();
      wb_rd(a, d);
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL reset_rd[%0d]: got %h want %h", a, d, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    adr = 7'd1; cyc = 1'b1; stb = 1'b1; we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_ack = (i % 2 == 0);
      checks++;
      if (ack !== exp_ack) begin
        errors++;
        $display("FAIL b2b_ack[%0d]: got %b want %b", i, ack, exp_ack);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    step(1);
  endtask

  task automatic test_legal_steps();
    logic [31:0] seq [8];
    logic [31:0] d;
    seq = '{32'd5, 32'd6, 32'd6, 32'd7,
            32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1};
    use_ctr = 1'b0;
    count_man = 32'd5;
    wb_wr(7'd0, 32'h1, 4'hF);
    step(2);
    foreach (seq[i]) begin
      count_man = seq[i];
      step(1);
    end
    step(2);
    exp_q.push_back(32'h0);
    wb_rd(7'd3, d);
    checks++;
    if (d !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL legal_err_cnt: got %h want 0", d);
    end
    checks++;
    if (mon_err !== 1'b0) begin
      errors++;
      $display("FAIL legal_mon_err: got %b want 0", mon_err);
    end
  endtask

  task automatic test_illegal_steps();
    logic [31:0] seq [4];
    logic [6:0]  a;
    logic [31:0] d, e;
    seq = '{32'd11, 32'd20, 32'd21, 32'd40};
    wb_wr(7'd0, 32'h0, 4'hF);
    count_man = 32'd10;
    step(1);
    wb_wr(7'd0, 32'h1, 4'hF);
    step(2);
    foreach (seq[i]) begin
      count_man = seq[i];
      step(1);
    end
    step(2);
    adr_q.push_back(7'd3); exp_q.push_back(32'd2);
    adr_q.push_back(7'd4); exp_q.push_back(32'd11);
    adr_q.push_back(7'd5); exp_q.push_back(32'd20);
    adr_q.push_back(7'd2); exp_q.push_back(32'h5);
    while (adr_q.size() > 0) begin
      a = adr_q.pop_front();
      e = exp_q.pop_front();
      wb_rd(a, d);
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL illegal_rd[%0d]: got %h want %h", a, d, e);
      end
    end
    checks++;
    if (mon_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_mon_err: got %b want 1", mon_err);
    end
    wb_wr(7'd0, 32'h100, 4'hF);
    adr_q.push_back(7'd0); exp_q.push_back(32'h0);
    adr_q.push_back(7'd2); exp_q.push_back(32'h4);
    adr_q.push_back(7'd3); exp_q.push_back(32'h0);
    adr_q.push_back(7'd4); exp_q.push_back(32'h0);
    adr_q.push_back(7'd5); exp_q.push_back(32'h0);
    while (adr_q.size() > 0) begin
      a = adr_q.pop_front();
      e = exp_q.pop_front();
      wb_rd(a, d);
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL clr_rd[%0d]: got %h want %h", a, d, e);
      end
    end
    checks++;
    if (mon_err !== 1'b0) begin
      errors++;
      $display("FAIL clr_mon_err: got %b want 0", mon_err);
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] d, e, c0;
    use_ctr = 1'b1;
    wb_wr(7'd1, 32'd4, 4'hF);
    wb_wr(7'd0, 32'h2, 4'hF);
    c0 = last_wr_ctr;
    for (int k = 1; k <= 3; k++)
      exp_q.push_back(c0 + 32'(4 * k));
    step(10);
    wb_rd(7'd2, d);
    checks++;
    if (d !== 32'h30) begin
      errors++;
      $display("FAIL snap_status: got %h want 00000030", d);
    end
    wb_wr(7'd0, 32'h0, 4'hF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wb_rd(7'd6, d);
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL snap_pop: got %h want %h", d, e);
      end
    end
    wb_rd(7'd2, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL snap_drained: got %h want 00000004", d);
    end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] d, e, c0;
    use_ctr = 1'b1;
    wb_wr(7'd1, 32'd2, 4'hF);
    wb_wr(7'd0, 32'h2, 4'hF);
    c0 = last_wr_ctr;
    for (int k = 1; k <= 9; k++)
      exp_q.push_back(c0 + 32'(2 * k));
    step(15);
    wb_rd(7'd6, d);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL full_pop: got %h want %h", d, e);
    end
    wb_rd(7'd2, d);
    checks++;
    if (d !== 32'h88) begin
      errors++;
      $display("FAIL pushpop_full: got %h want 00000088", d);
    end
    wb_wr(7'd0, 32'h0, 4'hF);
    wb_rd(7'd2, d);
    checks++;
    if (d !== 32'h8A) begin
      errors++;
      $display("FAIL ovf_status: got %h want 0000008a", d);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wb_rd(7'd6, d);
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL ovf_pop: got %h want %h", d, e);
      end
    end
    wb_rd(7'd2, d);
    checks++;
    if (d !== 32'h6) begin
      errors++;
      $display("FAIL ovf_drained: got %h want 00000006", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0]  a;
    logic [31:0] d, e;
    use_ctr = 1'b0;
    count_man = 32'd100;
    step(1);
    wb_wr(7'd0, 32'h3, 4'hF);
    step(2);
    count_man = 32'd500;
    step(4);
    checks++;
    if (mon_err !== 1'b1) begin
      errors++;
      $display("FAIL mid_err_set: got %b want 1", mon_err);
    end
    adr = 7'd2; cyc = 1'b1; stb = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL mid_ack_up: got %b want 1", ack);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_ack_drop: got %b want 0", ack);
    end
    checks++;
    if (mon_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_mon_err: got %b want 0", mon_err);
    end
    rst_n = 1'b1;
    cyc = 1'b0; stb = 1'b0;
    step(1);
    queue_reset_map();
    while (adr_q.size() > 0) begin
      a = adr_q.pop_front();
      e = exp_q.pop_front();
      wb_rd(a, d);
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL mid_rd[%0d]: got %h want %h", a, d, e);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_back_to_back();
    test_legal_steps();
    test_illegal_steps();
    test_snapshot();
    test_fifo_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
